uart_cmd_responder: RTL and testbench



---
 rtl/uart_cmd_responder_pkg.sv | 29 ++
 rtl/uart_cmd_timeout.sv | 34 +++
 rtl/uart_cmd_responder.sv | 117 +++++++++++
 tb/tb_uart_cmd_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_responder_pkg.sv
// Shared types and constants for the UART command responder.
package uart_cmd_responder_pkg;

  // One-hot state encoding; each bit doubles as a registered state decode.
  typedef enum logic [6:0] {
    StIdle     = 7'b000_0001,
    StGetData  = 7'b000_0010,
    StWrite    = 7'b000_0100,
    StReadReq  = 7'b000_1000,
    StReadCap  = 7'b001_0000,
    StSend     = 7'b010_0000,
    StWaitDone = 7'b100_0000
  } state_e;

  // Header byte layout: [7] = write(1)/read(0), [6:0] = register address.
  localparam int unsigned WR_BIT   = 7;
  localparam int unsigned ADDR_MSB = 6;
  localparam int unsigned ADDR_LSB = 0;

  // Inter-byte timeout in clk cycles: whole 10-bit characters at the line rate.
  function automatic int unsigned calc_timeout_cycles(input int unsigned clk_hz,
                                                      input int unsigned bps,
                                                      input int unsigned nbytes);
    return (clk_hz / bps) * 10 * nbytes;
  endfunction

  localparam int unsigned TIMEOUT_CYCLES = calc_timeout_cycles(50_000_000, 115_200, 2);

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable down-counter with clear, enable and terminal-count pulse.
module uart_cmd_timeout #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q;

  // Count state: clear beats load, load beats decrement; holds at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Terminal count fires on the enabled cycle that finds the counter at zero.
  always_comb begin
    tc_o = en_i && (count_q == '0);
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Far-end UART command responder: header/data bytes in, register bus
// accesses out, read data returned through the UART transmitter.
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 7,
  parameter int unsigned BPS           = 115_200,
  parameter int unsigned SYS_CLK_FREQ  = 50_000_000,
  parameter int unsigned TIMEOUT_BYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_en,
  input  logic                  tx_done,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  rx_overrun
);

  localparam int unsigned TimeoutCycles =
      calc_timeout_cycles(SYS_CLK_FREQ, BPS, TIMEOUT_BYTES);
  localparam logic [31:0] TimeoutLoad = 32'(TimeoutCycles - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] hdr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] tx_q;

  logic st_idle;
  logic st_get;
  logic to_load;
  logic to_clear;
  logic to_tc;

  assign st_idle = (state_q == StIdle);
  assign st_get  = (state_q == StGetData);

  // Arm the timer as a write header is accepted; drop it once GET_DATA resolves.
  assign to_load  = st_idle && rx_done && rx_data[WR_BIT];
  assign to_clear = st_get && (rx_done || to_tc);

  uart_cmd_timeout #(
    .Width(32)
  ) u_timeout (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (to_clear),
    .load_i    (to_load),
    .load_val_i(TimeoutLoad),
    .en_i      (st_get),
    .tc_o      (to_tc)
  );

  // Packet FSM together with header, data and transmit-byte registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hdr_q   <= '0;
      data_q  <= '0;
      tx_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_done) begin
            hdr_q   <= rx_data;
            state_q <= rx_data[WR_BIT] ? StGetData : StReadReq;
          end
        end
        StGetData: begin
          // A byte arriving on the terminal-count cycle still completes the write.
          if (rx_done) begin
            data_q  <= rx_data;
            state_q <= StWrite;
          end else if (to_tc) begin
            state_q <= StIdle;
          end
        end
        StWrite:   state_q <= StIdle;
        StReadReq: state_q <= StReadCap;
        StReadCap: begin
          tx_q    <= reg_rdata;
          state_q <= StSend;
        end
        StSend:    state_q <= StWaitDone;
        StWaitDone: begin
          if (tx_done) begin
            state_q <= StIdle;
          end
        end
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode straight from state bits and held registers.
  always_comb begin
    reg_addr    = hdr_q[ADDR_MSB:ADDR_LSB];
    reg_wdata   = data_q;
    tx_data     = tx_q;
    reg_wr      = (state_q == StWrite);
    reg_rd      = (state_q == StReadReq);
    tx_en       = (state_q == StSend);
    busy        = !st_idle;
    timeout_err = st_get && to_tc && !rx_done;
    rx_overrun  = rx_done && !st_idle && !st_get;
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: stimulus pushes expected bus and
// UART events, a negedge monitor pops and compares them as they appear.
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_done = 1'b0;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       timeout_err;
  logic       rx_overrun;

  logic [7:0]  mem [128];
  logic [14:0] exp_wr_q [$];
  logic [6:0]  exp_rd_q [$];
  logic [7:0]  exp_tx_q [$];
  int          exp_to = 0;
  int          exp_ov = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [14:0] mon_wr;
  logic [6:0]  mon_rd;
  logic [7:0]  mon_tx;

  uart_cmd_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_done    (tx_done),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .timeout_err(timeout_err),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  // Register file model: read data valid exactly one cycle after reg_rd.
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= mem[reg_addr];
    else        reg_rdata <= 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {3'b000, tx_data, tx_en, reg_addr, reg_wdata, reg_wr, reg_rd, busy, timeout_err,
            rx_overrun};
  endfunction

  // Monitor: every observed output event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr) begin
        if (exp_wr_q.size() == 0) check("unexpected_wr", 32'(reg_addr), 32'hFFFF_FFFF);
        else begin
          mon_wr = exp_wr_q.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(mon_wr[14:8]));
          check("wr_data", 32'(reg_wdata), 32'(mon_wr[7:0]));
        end
      end
      if (reg_rd) begin
        if (exp_rd_q.size() == 0) check("unexpected_rd", 32'(reg_addr), 32'hFFFF_FFFF);
        else begin
          mon_rd = exp_rd_q.pop_front();
          check("rd_addr", 32'(reg_addr), 32'(mon_rd));
        end
      end
      if (tx_en) begin
        if (exp_tx_q.size() == 0) check("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
        else begin
          mon_tx = exp_tx_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(mon_tx));
        end
      end
      if (timeout_err) begin
        if (exp_to == 0) check("unexpected_timeout", 32'(timeout_err), 32'h0);
        else exp_to--;
      end
      if (rx_overrun) begin
        if (exp_ov == 0) check("unexpected_overrun", 32'(rx_overrun), 32'h0);
        else begin
          exp_ov--;
          check("overrun_busy", 32'(busy), 32'h1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic wait_tx_en();
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_en) begin
        seen = 1'b1;
        break;
      end
    end
    check("tx_en_seen", 32'(seen), 32'h1);
  endtask

  task automatic finish_tx();
    @(posedge clk); #1;
    check("busy_wait_done", 32'(busy), 32'h1);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h33;
    mem[7'h12] = 8'hA7;
    mem[7'h20] = 8'h5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write 0x3C to 0x05; strobe in the cycle after the data byte
    exp_wr_q.push_back({7'h05, 8'h3C});
    send_byte(8'h85);
    @(negedge clk);
    check("busy_get_data", 32'(busy), 32'h1);
    send_byte(8'h3C);
    @(negedge clk);
    check("wr_latency", 32'(reg_wr), 32'h1);
    repeat (3) @(posedge clk);

    // Read 0x12 -> 0xA7 back over UART
    exp_rd_q.push_back(7'h12);
    exp_tx_q.push_back(8'hA7);
    send_byte(8'h12);
    wait_tx_en();
    repeat (3) @(posedge clk);
    finish_tx();

    // Timeout after a write header, then a clean write
    exp_to = 1;
    send_byte(8'h90);
    n = 0;
    for (int i = 1; i <= 9000; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        n = i;
        break;
      end
    end
    check("timeout_cycle", 32'(n), 32'd8680);
    exp_wr_q.push_back({7'h10, 8'h55});
    send_byte(8'h90);
    send_byte(8'h55);
    @(negedge clk);
    check("wr_after_timeout", 32'(reg_wr), 32'h1);
    repeat (3) @(posedge clk);

    // Overrun while waiting for the transmitter
    exp_rd_q.push_back(7'h20);
    exp_tx_q.push_back(8'h5A);
    send_byte(8'h20);
    wait_tx_en();
    exp_ov = 1;
    send_byte(8'hFF);
    repeat (2) @(posedge clk);
    finish_tx();
    repeat (3) @(posedge clk);

    // Data byte lands on the terminal-count cycle: write, no timeout
    exp_wr_q.push_back({7'h10, 8'h66});
    send_byte(8'h90);
    repeat (8678) @(posedge clk);
    send_byte(8'h66);
    @(negedge clk);
    check("wr_at_terminal", 32'(reg_wr), 32'h1);
    repeat (3) @(posedge clk);

    // Reset in GET_DATA
    send_byte(8'h81);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_packet_reset", out_vec(), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    exp_wr_q.push_back({7'h01, 8'h01});
    send_byte(8'h81);
    send_byte(8'h01);
    @(negedge clk);
    check("wr_after_reset", 32'(reg_wr), 32'h1);

    // Everything promised must have been seen
    repeat (10) @(posedge clk);
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'h0);
    check("rd_queue_empty", 32'(exp_rd_q.size()), 32'h0);
    check("tx_queue_empty", 32'(exp_tx_q.size()), 32'h0);
    check("timeout_pending", 32'(exp_to), 32'h0);
    check("overrun_pending", 32'(exp_ov), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
